// File: rtl/pipeline_stage_ctrl_pkg.sv
// Shared types and constants for the pipeline stage controller.
package pipeline_stage_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

  // Payload carried by the ID/EX, EX/MEM and MEM/WB registers
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
  } stage_t;

  // Payload carried by the IF/ID register
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_t;

  localparam int unsigned STAGE_W = $bits(stage_t);
  localparam int unsigned FETCH_W = $bits(fetch_t);

  // IF/ID reset value: empty slot presenting a NOP to decode
  localparam fetch_t IF_ID_RST = '{valid: 1'b0, inst: NOP_INST, pc: '0};

endpackage

// File: rtl/pipeline_stage_ctrl_pipe_reg.sv
// Pipeline register with hold, bubble (clear) and asynchronous reset.
module pipeline_stage_ctrl_pipe_reg #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold beats bubble; a bubble clears the whole entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (!hold) begin
      q <= bubble ? W'(0) : d;
    end
  end

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// PC and stage-register control: hold, bubble insertion, redirect and
// performance counters driven by the hazard unit's stop/redirect outputs.
module pipeline_stage_ctrl
  import pipeline_stage_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_inst,
  input  logic             if_id_stop,
  input  logic             id_ex_stop,
  input  logic             ex_mem_stop,
  input  logic             mem_wb_stop,
  input  logic             update_pc,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      pc,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [31:0]      ex_pc,
  output logic [31:0]      mem_pc,
  output logic [31:0]      wb_pc,
  output logic             id_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  fetch_t if_id_d, if_id_q;
  stage_t id_ex_d, id_ex_q, ex_mem_q, mem_wb_q;
  logic   id_issued;

  // Stage inputs: IF/ID always captures the fetch; ID/EX drops an already-issued entry
  always_comb begin
    if_id_d       = '{valid: 1'b1, inst: if_inst, pc: pc};
    id_ex_d       = '{valid: if_id_q.valid & ~id_issued, pc: if_id_q.pc};
  end

  // Fetch address: redirect has priority over the IF/ID stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (update_pc) begin
      pc <= redirect_pc;
    end else if (!if_id_stop) begin
      pc <= pc + PC_STEP;
    end
  end

  // Marks a held ID entry that has already been passed into EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_issued <= 1'b0;
    end else if (!if_id_stop) begin
      id_issued <= 1'b0;
    end else if (!id_ex_stop) begin
      id_issued <= 1'b1;
    end
  end

  pipeline_stage_ctrl_pipe_reg #(.W(FETCH_W), .RST_VAL(IF_ID_RST)) u_if_id (
    .clk(clk), .rst(rst), .hold(if_id_stop), .bubble(1'b0),
    .d(if_id_d), .q(if_id_q)
  );

  pipeline_stage_ctrl_pipe_reg #(.W(STAGE_W)) u_id_ex (
    .clk(clk), .rst(rst), .hold(id_ex_stop), .bubble(1'b0),
    .d(id_ex_d), .q(id_ex_q)
  );

  pipeline_stage_ctrl_pipe_reg #(.W(STAGE_W)) u_ex_mem (
    .clk(clk), .rst(rst), .hold(ex_mem_stop), .bubble(id_ex_stop),
    .d(id_ex_q), .q(ex_mem_q)
  );

  pipeline_stage_ctrl_pipe_reg #(.W(STAGE_W)) u_mem_wb (
    .clk(clk), .rst(rst), .hold(mem_wb_stop), .bubble(ex_mem_stop),
    .d(ex_mem_q), .q(mem_wb_q)
  );

  // Performance counters, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      retire_cnt <= '0;
    end else begin
      if (if_id_stop) stall_cnt <= stall_cnt + CNT_W'(1);
      if (!id_ex_stop && !id_ex_d.valid) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (mem_wb_q.valid) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  assign id_inst   = if_id_q.inst;
  assign id_pc     = if_id_q.pc;
  assign id_valid  = if_id_q.valid;
  assign ex_pc     = id_ex_q.pc;
  assign ex_valid  = id_ex_q.valid;
  assign mem_pc    = ex_mem_q.pc;
  assign mem_valid = ex_mem_q.valid;
  assign wb_pc     = mem_wb_q.pc;
  assign wb_valid  = mem_wb_q.valid;

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Self-checking bench for pipeline_stage_ctrl.
module tb_pipeline_stage_ctrl;
  import pipeline_stage_ctrl_pkg::*;

  localparam int unsigned CW = 32;

  logic          clk, rst;
  logic [31:0]   if_inst, redirect_pc;
  logic          if_id_stop, id_ex_stop, ex_mem_stop, mem_wb_stop, update_pc;
  logic [31:0]   pc, id_inst, id_pc, ex_pc, mem_pc, wb_pc;
  logic          id_valid, ex_valid, mem_valid, wb_valid;
  logic [CW-1:0] stall_cnt, bubble_cnt, retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_stage_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .if_inst(if_inst),
    .if_id_stop(if_id_stop), .id_ex_stop(id_ex_stop),
    .ex_mem_stop(ex_mem_stop), .mem_wb_stop(mem_wb_stop),
    .update_pc(update_pc), .redirect_pc(redirect_pc),
    .pc(pc), .id_inst(id_inst), .id_pc(id_pc), .ex_pc(ex_pc),
    .mem_pc(mem_pc), .wb_pc(wb_pc), .id_valid(id_valid), .ex_valid(ex_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: content is a simple function of the address
  function automatic logic [31:0] imem(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction
  assign if_inst = imem(pc);

  typedef struct {
    logic        s_ifid, s_idex, s_exmem, s_memwb, upd;
    logic [31:0] rdir;
    logic [31:0] e_pc;
    logic [3:0]  e_v;  // {id, ex, mem, wb}
    logic [31:0] e_idpc, e_expc, e_mempc, e_wbpc;
    int unsigned e_bub, e_ret;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] sb_q[$];

  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] rdir,
                              input logic [31:0] e_pc, input logic [3:0] e_v,
                              input logic [31:0] idpc, input logic [31:0] expc,
                              input logic [31:0] mempc, input logic [31:0] wbpc,
                              input int unsigned bub, input int unsigned ret);
    vec_t v;
    v.s_ifid = ctl[4]; v.s_idex = ctl[3]; v.s_exmem = ctl[2];
    v.s_memwb = ctl[1]; v.upd = ctl[0];
    v.rdir = rdir; v.e_pc = e_pc; v.e_v = e_v;
    v.e_idpc = idpc; v.e_expc = expc; v.e_mempc = mempc; v.e_wbpc = wbpc;
    v.e_bub = bub; v.e_ret = ret;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] ctl, input logic [31:0] rdir);
    if_id_stop  = ctl[4];
    id_ex_stop  = ctl[3];
    ex_mem_stop = ctl[2];
    mem_wb_stop = ctl[1];
    update_pc   = ctl[0];
    redirect_pc = rdir;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_valids"}, 32'({id_valid, ex_valid, mem_valid, wb_valid}), 32'h0);
    chk({tag, "_id_inst"}, id_inst, NOP_INST);
    chk({tag, "_stage_pcs"}, id_pc | ex_pc | mem_pc | wb_pc, 32'h0);
    chk({tag, "_stall"}, stall_cnt, 32'h0);
    chk({tag, "_bubble"}, bubble_cnt, 32'h0);
    chk({tag, "_retire"}, retire_cnt, 32'h0);
  endtask

  initial begin
    int unsigned stall_model;
    int unsigned pops;
    logic [31:0] model_pc;
    logic [31:0] exp_pc;
    vec_t v;

    // Cycle-by-cycle vectors starting from reset
    vecs[0]  = mk(5'b00000, 32'h0,   32'h04,  4'b1000, 32'h00, 32'h00, 32'h00, 32'h00, 1, 0);
    vecs[1]  = mk(5'b00000, 32'h0,   32'h08,  4'b1100, 32'h04, 32'h00, 32'h00, 32'h00, 1, 0);
    vecs[2]  = mk(5'b00000, 32'h0,   32'h0C,  4'b1110, 32'h08, 32'h04, 32'h00, 32'h00, 1, 0);
    vecs[3]  = mk(5'b00000, 32'h0,   32'h10,  4'b1111, 32'h0C, 32'h08, 32'h04, 32'h00, 1, 0);
    vecs[4]  = mk(5'b00000, 32'h0,   32'h14,  4'b1111, 32'h10, 32'h0C, 32'h08, 32'h04, 1, 1);
    // Branch at 0x10 held in ID for three cycles, redirect on the second
    vecs[5]  = mk(5'b10000, 32'h0,   32'h14,  4'b1111, 32'h10, 32'h10, 32'h0C, 32'h08, 1, 2);
    vecs[6]  = mk(5'b10001, 32'h40,  32'h40,  4'b1011, 32'h10, 32'h00, 32'h10, 32'h0C, 2, 3);
    vecs[7]  = mk(5'b10000, 32'h0,   32'h40,  4'b1001, 32'h10, 32'h00, 32'h00, 32'h10, 3, 4);
    vecs[8]  = mk(5'b00000, 32'h0,   32'h44,  4'b1000, 32'h40, 32'h00, 32'h00, 32'h00, 4, 5);
    vecs[9]  = mk(5'b00000, 32'h0,   32'h48,  4'b1100, 32'h44, 32'h40, 32'h00, 32'h00, 4, 5);
    vecs[10] = mk(5'b00000, 32'h0,   32'h4C,  4'b1110, 32'h48, 32'h44, 32'h40, 32'h00, 4, 5);
    // IF/ID and ID/EX stopped together: bubble into MEM only
    vecs[11] = mk(5'b11000, 32'h0,   32'h4C,  4'b1101, 32'h48, 32'h44, 32'h00, 32'h40, 4, 5);
    // Redirect while IF/ID is stopped
    vecs[12] = mk(5'b10001, 32'h100, 32'h100, 4'b1110, 32'h48, 32'h48, 32'h44, 32'h00, 4, 6);
    vecs[13] = mk(5'b00100, 32'h0,   32'h104, 4'b1010, 32'h100, 32'h00, 32'h44, 32'h00, 5, 6);
    vecs[14] = mk(5'b00010, 32'h0,   32'h108, 4'b1100, 32'h104, 32'h100, 32'h00, 32'h00, 5, 6);
    vecs[15] = mk(5'b00000, 32'h0,   32'h10C, 4'b1110, 32'h108, 32'h104, 32'h100, 32'h00, 5, 6);
    vecs[16] = mk(5'b11110, 32'h0,   32'h10C, 4'b1110, 32'h108, 32'h104, 32'h100, 32'h00, 5, 6);
    vecs[17] = mk(5'b00000, 32'h0,   32'h110, 4'b1111, 32'h10C, 32'h108, 32'h104, 32'h100, 5, 6);

    drive(5'b00000, 32'h0);
    do_reset();
    chk_reset_state("reset");

    // Free run: fetched PCs queued, popped as they retire
    model_pc = 32'h0;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back(model_pc);
      model_pc = model_pc + 32'h4;
      tick();
      if (wb_valid) begin
        pops++;
        if (sb_q.size() == 0) chk("sb_underflow", wb_pc, 32'hFFFF_FFFF);
        else begin
          exp_pc = sb_q.pop_front();
          chk($sformatf("sb_wb_pc%0d", pops), wb_pc, exp_pc);
        end
      end
    end
    chk("run_pc", pc, 32'h20);
    chk("run_retire_cnt", retire_cnt, 32'd4);
    chk("run_retired", 32'(pops), 32'd5);
    sb_q.delete();

    // Table-driven sequence
    do_reset();
    stall_model = 0;
    for (int i = 0; i < 18; i++) begin
      v = vecs[i];
      drive({v.s_ifid, v.s_idex, v.s_exmem, v.s_memwb, v.upd}, v.rdir);
      tick();
      if (v.s_ifid) stall_model++;
      chk($sformatf("r%0d_pc", i), pc, v.e_pc);
      chk($sformatf("r%0d_valid", i), 32'({id_valid, ex_valid, mem_valid, wb_valid}), 32'(v.e_v));
      if (v.e_v[3]) begin
        chk($sformatf("r%0d_id_pc", i), id_pc, v.e_idpc);
        chk($sformatf("r%0d_id_inst", i), id_inst, imem(v.e_idpc));
      end
      if (v.e_v[2]) chk($sformatf("r%0d_ex_pc", i), ex_pc, v.e_expc);
      if (v.e_v[1]) chk($sformatf("r%0d_mem_pc", i), mem_pc, v.e_mempc);
      if (v.e_v[0]) chk($sformatf("r%0d_wb_pc", i), wb_pc, v.e_wbpc);
      chk($sformatf("r%0d_stall", i), stall_cnt, 32'(stall_model));
      chk($sformatf("r%0d_bubble", i), bubble_cnt, 32'(v.e_bub));
      chk($sformatf("r%0d_retire", i), retire_cnt, 32'(v.e_ret));
    end

    // PC wrap at the top of the address space
    drive(5'b00001, 32'hFFFF_FFFC);
    tick();
    chk("wrap_redirect_pc", pc, 32'hFFFF_FFFC);
    drive(5'b00000, 32'h0);
    tick();
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_id_inst", id_inst, imem(32'hFFFF_FFFC));

    // Asynchronous reset mid-cycle discards everything at once
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("async_rst");
    tick();
    chk_reset_state("rst_held");
    rst = 1'b0;
    tick();
    chk("post_rst_pc", pc, 32'h4);
    chk("post_rst_id", 32'({id_valid, ex_valid}), 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
